// File: rtl/simple_pattern_checker.sv
// simple_pattern_checker
// Receive-side checker for the counter/shift stimulus generator. Locks onto
// the first accepted sample, then predicts every following sample from its
// own expected values and flags add/shift mismatches. It keeps a sticky fail
// flag and saturating error and sample counters, and halts once the error
// count reaches ERR_LIMIT.
module simple_pattern_checker #(
  parameter int ADD_W     = 2,
  parameter int SHIFT_W   = 127,
  parameter int ERR_LIMIT = 4,
  parameter int ERR_CNT_W = 8,
  parameter int SMP_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 in_valid,
  input  logic [ADD_W-1:0]     in_add,
  input  logic [SHIFT_W-1:0]   in_shift,
  output logic                 locked,
  output logic                 halted,
  output logic                 err_add,
  output logic                 err_shift,
  output logic                 fail,
  output logic                 shift_full,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [SMP_CNT_W-1:0] sample_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_HALT
  } state_t;

  state_t               state;
  logic [ADD_W-1:0]     exp_add;
  logic [SHIFT_W-1:0]   exp_shift;

  logic                 add_bad;
  logic                 shift_bad;
  logic                 halt_now;
  logic                 in_shift_full;
  logic [ADD_W-1:0]     seed_add;
  logic [SHIFT_W-1:0]   seed_shift;
  logic [ADD_W-1:0]     exp_add_next;
  logic [SHIFT_W-1:0]   exp_shift_next;
  logic [ERR_CNT_W-1:0] err_count_inc;
  logic [SMP_CNT_W-1:0] sample_count_inc;

  // Compare, predict and saturate: everything the sequential block needs for this cycle.
  always_comb begin
    // NOTE: every signal gets a default first so no path through this block leaves it unassigned and infers a latch.
    add_bad          = 1'b0;
    shift_bad        = 1'b0;
    halt_now         = 1'b0;
    in_shift_full    = 1'b0;
    seed_add         = '0;
    seed_shift       = '0;
    exp_add_next     = '0;
    exp_shift_next   = '0;
    err_count_inc    = err_count;
    sample_count_inc = sample_count;

    add_bad       = (in_add != exp_add);
    shift_bad     = (in_shift != exp_shift);
    in_shift_full = &in_shift;

    // The seed predicts the sample after the observed one. Later predictions
    // advance from the checker's own expected values only.
    // The shift is written this way so that it is also legal when SHIFT_W == 2.
    seed_add       = in_add + ADD_W'(1);
    seed_shift     = (in_shift << 2) | SHIFT_W'(3);
    exp_add_next   = exp_add + ADD_W'(1);
    exp_shift_next = (exp_shift << 2) | SHIFT_W'(3);

    if (!(&err_count)) begin
      err_count_inc = err_count + ERR_CNT_W'(1);
    end
    if (!(&sample_count)) begin
      sample_count_inc = sample_count + SMP_CNT_W'(1);
    end
    halt_now = (err_count_inc == ERR_CNT_W'(ERR_LIMIT));
  end

  // State machine, predictor and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments, so every register here sees the values from before the edge.
      state        <= S_IDLE;
      exp_add      <= '0;
      exp_shift    <= '0;
      locked       <= 1'b0;
      halted       <= 1'b0;
      err_add      <= 1'b0;
      err_shift    <= 1'b0;
      fail         <= 1'b0;
      shift_full   <= 1'b0;
      err_count    <= '0;
      sample_count <= '0;
    end else begin
      // Pulses default low. They are raised only for the cycle after a mismatching sample.
      err_add   <= 1'b0;
      err_shift <= 1'b0;

      if (clear) begin
        state        <= S_IDLE;
        exp_add      <= '0;
        exp_shift    <= '0;
        locked       <= 1'b0;
        halted       <= 1'b0;
        fail         <= 1'b0;
        shift_full   <= 1'b0;
        err_count    <= '0;
        sample_count <= '0;
      end else if (in_valid) begin
        unique case (state)
          S_IDLE: begin
            exp_add      <= seed_add;
            exp_shift    <= seed_shift;
            sample_count <= SMP_CNT_W'(1);
            shift_full   <= in_shift_full;
            state        <= S_CHECK;
            locked       <= 1'b1;
          end
          S_CHECK: begin
            exp_add      <= exp_add_next;
            exp_shift    <= exp_shift_next;
            sample_count <= sample_count_inc;
            shift_full   <= in_shift_full;
            err_add      <= add_bad;
            err_shift    <= shift_bad;
            if (add_bad || shift_bad) begin
              fail      <= 1'b1;
              err_count <= err_count_inc;
              if (halt_now) begin
                state  <= S_HALT;
                locked <= 1'b0;
                halted <= 1'b1;
              end
            end
          end
          S_HALT: begin
            // Frozen until clear or reset.
          end
          default: begin
            state  <= S_IDLE;
            locked <= 1'b0;
            halted <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/simple_pattern_checker.md
# simple_pattern_checker

Receive-side checker for the Simple counter/shift stimulus generator used in the waveform integration tests. It samples the 2-bit wrap-around add counter and the SHIFT_W-bit shift register, predicts the next value of each, and flags mismatches, with sticky failure status and saturating error/sample counters. It sits beside the generator in integration-test top levels, so the test exercises both the generator and its checker.

## Interface
- ADD_W, 2, width of add-counter sample
- SHIFT_W, 127, width of shift-register sample; must be ≥ 2
- ERR_LIMIT, 4, error count at which checking halts; 1..2^ERR_CNT_W-1
- ERR_CNT_W, 8, err_count width
- SMP_CNT_W, 16, sample_count width
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous restart to IDLE; priority over in_valid
- in_valid  in  1  sample qualifier; in_add/in_shift are sampled when high
- in_add  in  ADD_W  observed add counter
- in_shift  in  SHIFT_W  observed shift register
- locked  out  1  high in CHECK
- halted  out  1  high in HALT
- err_add  out  1  one-cycle pulse: add mismatch
- err_shift  out  1  one-cycle pulse: shift mismatch
- fail  out  1  sticky: any mismatch since reset/clear
- shift_full  out  1  last accepted in_shift was all ones
- err_count  out  ERR_CNT_W  erroneous samples, saturating
- sample_count  out  SMP_CNT_W  accepted samples, including seed; saturating

## Operation
- Predictor: exp_add' = exp_add + 1 mod 2^ADD_W; exp_shift' = {exp_shift[SHIFT_W-3:0], 2'b11}. Shift saturates to all ones after ceil(SHIFT_W/2) steps (64 for 127).
- States: IDLE → CHECK → HALT. Encoding is internal.
- IDLE: on in_valid, seed exp_* with the advanced observed sample (predict next), sample_count ← 1, go CHECK. No comparison on the seed sample, so lock works mid-stream.
- CHECK: on in_valid, compare in_add to exp_add and in_shift to exp_shift. err_add / err_shift pulse independently; if either mismatches: fail ← 1, err_count +1 (one per sample, even when both fields mismatch). Predictor always advances from its own expected values, never from observed data, so one glitch yields exactly one error.
- CHECK → HALT on the sample that makes err_count == ERR_LIMIT. That sample's pulses still fire.
- HALT: no comparisons, pulses stay low, counters and predictor are frozen. Exit only via clear or rst_n.
- in_valid low: predictor, counters and state hold. Gaps are not errors.
- clear (any state): state IDLE, err_count 0, sample_count 0, fail 0, pulses 0, shift_full 0; in_valid that cycle is ignored.
- Counters saturate at all ones; they never wrap.
- shift_full updates on every accepted sample, including the seed.

## Timing
- All outputs registered. A sample accepted at rising edge N produces err_*, counter updates, shift_full and state change visible after edge N. Pulses last exactly one cycle, until edge N+1, unless the next sample also mismatches.
- Latency from sample to flag: 1 edge. Throughput: one sample per cycle.
- Reset values (asynchronous, immediate on rst_n low, including mid-CHECK): state IDLE, exp_* 0, every output 0.
- First sample after reset release is treated as the seed.

## Test plan
- Golden from reset: after rst_n release, drive add=0, shift=0, then 70 generator steps with in_valid=1 → locked=1 after first edge; err_count=0, fail=0; sample_count=71; shift_full=1 from the sample at step 64 onward.
- Mid-stream lock and gaps: seed add=2, shift=0xF, then add=3, shift=0x3F, idle 3 cycles, then add=0, shift=0xFF → no errors, sample_count=3.
- Single add glitch: golden stream, sample 5 driven as add+1 → err_add high exactly 1 cycle, err_shift=0, err_count=1, fail=1; later golden samples produce no further errors.
- Simultaneous mismatch: one sample with add and shift both wrong → err_add and err_shift pulse in the same cycle, err_count increments by 1.
- Limit and clear: ERR_LIMIT=4, inject 6 bad samples → halted=1 after the 4th, err_count stays 4, sample_count frozen, no pulses on the 5th or 6th; clear with in_valid=1 → next cycle IDLE, all counters 0, fail=0, and the following sample seeds.
- Asynchronous reset mid-CHECK: drop rst_n between edges with fail=1 → all outputs 0 before the next edge; after release, the first sample re-seeds.
